// File: rtl/prog_loader.sv
// Boot-time program loader: parses a SYNC/count/payload byte stream into 19-bit memory writes.
// Optional trailing XOR checksum byte when LOADER_CSUM_EN is defined.
module prog_loader #(
    parameter int unsigned DATA_W    = 19,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MEM_DEPTH = 256,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              start,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

`ifdef LOADER_CSUM_EN
    typedef enum logic [3:0] {
        S_IDLE, S_CNT_HI, S_CNT_LO, S_W0, S_W1, S_W2, S_CSUM, S_DONE, S_ERR
    } state_t;
    localparam state_t S_END = S_CSUM;
`else
    typedef enum logic [3:0] {
        S_IDLE, S_CNT_HI, S_CNT_LO, S_W0, S_W1, S_W2, S_DONE, S_ERR
    } state_t;
    localparam state_t S_END = S_DONE;
`endif

    state_t      state, state_nx;
    logic        xfer;
    logic [7:0]  cnt_hi;
    logic [15:0] count;
    logic [15:0] cnt_full;
    logic [15:0] idx;
    logic [2:0]  b0;
    logic [7:0]  b1;
    logic        last_word;
`ifdef LOADER_CSUM_EN
    logic [7:0]  csum;
`endif

    assign xfer      = in_valid & in_ready;
    assign cnt_full  = {cnt_hi, in_data};
    assign last_word = (idx + 16'd1 == count);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (xfer && in_data == SYNC_BYTE) state_nx = S_CNT_HI;
            S_CNT_HI: if (xfer) state_nx = S_CNT_LO;
            S_CNT_LO: if (xfer) begin
                if (cnt_full > 16'(MEM_DEPTH)) state_nx = S_ERR;
                else if (cnt_full == '0)      state_nx = S_END;
                else                          state_nx = S_W0;
            end
            S_W0:     if (xfer) state_nx = (in_data[7:3] != '0) ? S_ERR : S_W1;
            S_W1:     if (xfer) state_nx = S_W2;
            S_W2:     if (xfer) state_nx = last_word ? S_END : S_W0;
`ifdef LOADER_CSUM_EN
            S_CSUM:   if (xfer) state_nx = (in_data == csum) ? S_DONE : S_ERR;
`endif
            S_DONE:   if (start) state_nx = S_IDLE;
            S_ERR:    if (start) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state != S_DONE) && (state != S_ERR);
        done     = (state == S_DONE);
        error    = (state == S_ERR);
        cpu_hold = (state != S_DONE);
    end

    // Word write is registered off the third byte, so it lands one cycle after W2 accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cnt_hi    <= '0;
            count     <= '0;
            idx       <= '0;
            b0        <= '0;
            b1        <= '0;
        end else begin
            mem_we <= 1'b0;
            if (xfer) begin
                case (state)
                    S_IDLE:   idx <= '0;
                    S_CNT_HI: cnt_hi <= in_data;
                    S_CNT_LO: count <= cnt_full;
                    S_W0:     b0 <= in_data[2:0];
                    S_W1:     b1 <= in_data;
                    S_W2: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= idx[ADDR_W-1:0];
                        mem_wdata <= DATA_W'({b0, b1, in_data});
                        idx       <= idx + 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef LOADER_CSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            csum <= '0;
        end else if (xfer) begin
            if (state == S_IDLE)
                csum <= '0;
            else if (state == S_CNT_HI || state == S_CNT_LO || state == S_W0 ||
                     state == S_W1 || state == S_W2)
                csum <= csum ^ in_data;
        end
    end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frame-level parser model plus per-cycle write-port checker.
module tb_prog_loader;
    typedef logic [7:0] bytes_t[$];

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        start;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [18:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    logic [26:0] expq[$];
    logic [26:0] mw[$];
    int          m_status;
    int          m_used;
    logic [7:0]  last_addr;
    logic [18:0] last_data;
    int          we_count;
    logic        hold_at_we;

    always #5 clk = ~clk;

    prog_loader dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .start(start), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Frame parser: status 0 = still in frame, 1 = done, 2 = error; m_used = bytes accepted.
    function automatic void model(input bytes_t b);
        int         p;
        int         n;
        logic [7:0] x;
        logic [7:0] c0;
        mw.delete();
        m_status = 0;
        m_used   = b.size();
        p        = 0;
        while (p < b.size() && b[p] != 8'hA5) p++;
        if (p >= b.size()) return;
        p++;
        if (p + 2 > b.size()) return;
        n = {16'd0, b[p], b[p+1]};
        x = b[p] ^ b[p+1];
        p += 2;
        if (n > 256) begin
            m_status = 2;
            m_used   = p;
            return;
        end
        for (int w = 0; w < n; w++) begin
            if (p >= b.size()) return;
            c0 = b[p];
            if (c0[7:3] != 5'd0) begin
                m_status = 2;
                m_used   = p + 1;
                return;
            end
            if (p + 3 > b.size()) return;
            mw.push_back({8'(w), c0[2:0], b[p+1], b[p+2]});
            x ^= b[p] ^ b[p+1] ^ b[p+2];
            p += 3;
        end
`ifdef LOADER_CSUM_EN
        if (p >= b.size()) return;
        m_status = (b[p] == x) ? 1 : 2;
        m_used   = p + 1;
`else
        m_status = 1;
        m_used   = p;
`endif
    endfunction

    task automatic run(input string name, input bytes_t f, input int gap, input int exp_status);
        model(f);
        chk({name, ":model_status"}, m_status, exp_status);
        foreach (mw[i]) expq.push_back(mw[i]);
        for (int i = 0; i < m_used; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = f[i];
            chk({name, ":in_ready"}, in_ready, 1);
            if (gap > 0 && i < m_used - 1) begin
                @(negedge clk);
                in_valid = 1'b0;
                repeat (gap - 1) @(negedge clk);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk({name, ":done"}, done, (exp_status == 1));
        chk({name, ":error"}, error, (exp_status == 2));
        chk({name, ":cpu_hold"}, cpu_hold, (exp_status != 1));
        chk({name, ":in_ready_end"}, in_ready, (exp_status == 0));
        chk({name, ":writes_left"}, expq.size(), 0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("rearm:done", done, 0);
        chk("rearm:error", error, 0);
        chk("rearm:cpu_hold", cpu_hold, 1);
        chk("rearm:in_ready", in_ready, 1);
    endtask

    initial begin
        last_addr = '0;
        last_data = '0;
        we_count  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                last_addr = '0;
                last_data = '0;
                chk("reset_we", mem_we, 0);
                chk("reset_addr", mem_addr, 0);
                chk("reset_wdata", mem_wdata, 0);
            end else if (mem_we) begin
                we_count++;
                hold_at_we = cpu_hold;
                if (expq.size() == 0) begin
                    chk("unexpected_write", mem_we, 0);
                end else begin
                    logic [26:0] e;
                    e = expq.pop_front();
                    chk("wr_addr", mem_addr, e[26:19]);
                    chk("wr_data", mem_wdata, e[18:0]);
                    last_addr = mem_addr;
                    last_data = mem_wdata;
                end
            end else begin
                chk("hold_addr", mem_addr, last_addr);
                chk("hold_wdata", mem_wdata, last_data);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        bytes_t t1, t2, t3, t4, t5;
        int     wc0;

        t1 = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h00, 8'h12, 8'h07, 8'hFF, 8'hFF};
        t2 = '{8'h3C, 8'h11, 8'hA5, 8'h00, 8'h01, 8'h01, 8'h23, 8'h45};
        t3 = '{8'hA5, 8'h01, 8'h01};
        t4 = '{8'hA5, 8'h00, 8'h01, 8'h08, 8'h00, 8'h00};
        t5 = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h00};
`ifdef LOADER_CSUM_EN
        t1.push_back(8'h17);
        t2.push_back(8'h66);
`endif

        model(t1);
        chk("pin:t1_count", mw.size(), 2);
        chk("pin:t1_w0", mw[0], {8'h00, 19'h00012});
        chk("pin:t1_w1", mw[1], {8'h01, 19'h7FFFF});
        chk("pin:t1_used", m_used, t1.size());
        model(t2);
        chk("pin:t2_w0", mw[0], {8'h00, 19'h12345});
        model(t4);
        chk("pin:t4_used", m_used, 4);

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        start    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst:in_ready", in_ready, 1);
        chk("rst:mem_we", mem_we, 0);
        chk("rst:mem_addr", mem_addr, 0);
        chk("rst:mem_wdata", mem_wdata, 0);
        chk("rst:cpu_hold", cpu_hold, 1);
        chk("rst:done", done, 0);
        chk("rst:error", error, 0);
        reset = 1'b0;

        wc0 = we_count;
        run("t1", t1, 0, 1);
        chk("t1:we_cycles", we_count - wc0, 2);
`ifdef LOADER_CSUM_EN
        chk("t1:hold_at_last_we", hold_at_we, 1);
`else
        chk("t1:hold_at_last_we", hold_at_we, 0);
`endif
        pulse_start();

        run("t2", t2, 0, 1);
        pulse_start();

        wc0 = we_count;
        run("t3", t3, 0, 2);
        chk("t3:no_write", we_count - wc0, 0);
        pulse_start();

        wc0 = we_count;
        run("t4", t4, 0, 2);
        chk("t4:no_write", we_count - wc0, 0);
        pulse_start();

        wc0 = we_count;
        run("t1gap", t1, 3, 1);
        chk("t1gap:we_cycles", we_count - wc0, 2);
        pulse_start();

        wc0 = we_count;
        run("t5", t5, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("t5:no_write", we_count - wc0, 0);
        chk("t5:cpu_hold", cpu_hold, 1);
        chk("t5:in_ready", in_ready, 1);
        chk("t5:done", done, 0);
        run("t5full", t1, 0, 1);
        pulse_start();

`ifdef LOADER_CSUM_EN
        begin
            bytes_t t6;
            t6 = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h00, 8'h12, 8'h07, 8'hFF, 8'hFF, 8'h00};
            wc0 = we_count;
            run("t6bad", t6, 0, 2);
            chk("t6bad:we_cycles", we_count - wc0, 2);
            pulse_start();
        end
`endif

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
